// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

    // Counting mode of the shared time base.
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Default widths and channel count.
    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 16;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration and status bundle of pwm_multi.
// The controller (master) drives the settings and the PWM block (slave) returns its outputs.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
);
    logic                    enable;
    logic [PSC_W-1:0]        psc;
    logic [CNT_W-1:0]        top;
    logic                    center;
    logic [N_CH*CNT_W-1:0]   cr1;
    logic [N_CH*CNT_W-1:0]   cr2;
    logic                    load;
    logic [N_CH-1:0]         pwm;
    logic [CNT_W-1:0]        count;
    logic                    period_tick;
    logic                    pending;

    modport master (
        output enable, psc, top, center, cr1, cr2, load,
        input  pwm, count, period_tick, pending
    );

    modport slave (
        input  enable, psc, top, center, cr1, cr2, load,
        output pwm, count, period_tick, pending
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: produces one tick every psc+1 clocks while enabled.
// psc is used live; a counter left above a newly lowered psc wraps to 0 on the next clock.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

    // Next prescale count: increment, wrap at (or past) psc, clear when stopped.
    always_comb begin
        psc_cnt_d = psc_cnt_q + PSC_W'(1);
        if (!enable || (psc_cnt_q >= psc)) begin
            psc_cnt_d = '0;
        end
    end

    // Prescale counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

    assign tick = enable && (psc_cnt_q == psc);
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled time base (edge or center aligned)
// and double-buffered period/mode/compare settings applied at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    pwm_multi_if.slave bus
);
    logic                        tick;
    logic                        boundary;
    logic                        apply;

    logic [CNT_W-1:0]            count_q, count_d;
    logic                        up_q, up_d;
    logic                        pending_q, pending_d;
    logic                        period_tick_q, period_tick_d;

    // Shadow (_s) and active (_a) copies of the buffered settings.
    logic [CNT_W-1:0]            top_s_q, top_s_d, top_a_q, top_a_d;
    pwm_mode_e                   mode_s_q, mode_s_d, mode_a_q, mode_a_d;
    logic [N_CH-1:0][CNT_W-1:0]  cr1_s_q, cr1_s_d, cr1_a_q, cr1_a_d;
    logic [N_CH-1:0][CNT_W-1:0]  cr2_s_q, cr2_s_d, cr2_a_q, cr2_a_d;

    logic [N_CH-1:0]             pwm_bits;

    pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .psc    (bus.psc),
        .tick   (tick)
    );

    // Period boundary: edge mode ends at top, center mode at the down-to-up turn at 0.
    // A zero period makes every tick a boundary.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (top_a_q == '0) begin
                boundary = 1'b1;
            end else if (mode_a_q == PWM_EDGE) begin
                boundary = (count_q == top_a_q);
            end else begin
                boundary = (count_q == '0) && !up_q;
            end
        end
        apply = boundary && pending_q;
    end

    // Shadow capture on load; active copy follows shadow while stopped, else updates at boundary.
    // A load coinciding with a boundary leaves the old shadow to be applied and stays pending.
    always_comb begin
        top_s_d   = top_s_q;
        mode_s_d  = mode_s_q;
        cr1_s_d   = cr1_s_q;
        cr2_s_d   = cr2_s_q;
        if (bus.load) begin
            top_s_d  = bus.top;
            mode_s_d = pwm_mode_e'(bus.center);
            cr1_s_d  = bus.cr1;
            cr2_s_d  = bus.cr2;
        end

        top_a_d   = top_a_q;
        mode_a_d  = mode_a_q;
        cr1_a_d   = cr1_a_q;
        cr2_a_d   = cr2_a_q;
        pending_d = pending_q;
        if (!bus.enable) begin
            top_a_d   = top_s_d;
            mode_a_d  = mode_s_d;
            cr1_a_d   = cr1_s_d;
            cr2_a_d   = cr2_s_d;
            pending_d = 1'b0;
        end else begin
            if (apply) begin
                top_a_d  = top_s_q;
                mode_a_d = mode_s_q;
                cr1_a_d  = cr1_s_q;
                cr2_a_d  = cr2_s_q;
            end
            if (bus.load) begin
                pending_d = 1'b1;
            end else if (apply) begin
                pending_d = 1'b0;
            end
        end
    end

    // Time base: the period restarts against the (possibly new) active settings.
    // Staying in center mode restarts at 1 so 0 is held only one tick; a mode switch restarts at 0.
    always_comb begin
        count_d = count_q;
        up_d    = up_q;
        if (!bus.enable) begin
            count_d = '0;
            up_d    = 1'b1;
        end else if (boundary) begin
            up_d    = 1'b1;
            count_d = '0;
            if ((top_a_d != '0) && (mode_a_d == PWM_CENTER) && (mode_a_d == mode_a_q)) begin
                count_d = CNT_W'(1);
            end
        end else if (tick) begin
            if (mode_a_q == PWM_EDGE) begin
                count_d = count_q + CNT_W'(1);
            end else if (up_q) begin
                if (count_q >= top_a_q) begin
                    count_d = count_q - CNT_W'(1);
                    up_d    = 1'b0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
        period_tick_d = boundary;
    end

    // Time base, shadow and active registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q       <= '0;
            up_q          <= 1'b1;
            pending_q     <= 1'b0;
            period_tick_q <= 1'b0;
            top_s_q       <= '0;
            mode_s_q      <= PWM_EDGE;
            cr1_s_q       <= '0;
            cr2_s_q       <= '0;
            top_a_q       <= '0;
            mode_a_q      <= PWM_EDGE;
            cr1_a_q       <= '0;
            cr2_a_q       <= '0;
        end else begin
            count_q       <= count_d;
            up_q          <= up_d;
            pending_q     <= pending_d;
            period_tick_q <= period_tick_d;
            top_s_q       <= top_s_d;
            mode_s_q      <= mode_s_d;
            cr1_s_q       <= cr1_s_d;
            cr2_s_q       <= cr2_s_d;
            top_a_q       <= top_a_d;
            mode_a_q      <= mode_a_d;
            cr1_a_q       <= cr1_a_d;
            cr2_a_q       <= cr2_a_d;
        end
    end

    // Per-channel compare window and output flop; output trails count by one clock.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic pwm_d, pwm_q;

        // Window test against the current count and active compares.
        always_comb begin
            pwm_d = bus.enable && (count_q >= cr1_a_q[i]) && (count_q < cr2_a_q[i]);
        end

        // Registered channel output.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= pwm_d;
            end
        end

        assign pwm_bits[i] = pwm_q;
    end

    assign bus.pwm         = pwm_bits;
    assign bus.count       = count_q;
    assign bus.period_tick = period_tick_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center time base, shadowing, degenerate windows,
// prescaler wrap, reset and enable behaviour.
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;
    localparam int PSC_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    pwm_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) bus ();

    pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int ch, input int lo, input int hi);
        bus.cr1[ch*CNT_W +: CNT_W] = CNT_W'(lo);
        bus.cr2[ch*CNT_W +: CNT_W] = CNT_W'(hi);
    endtask

    // Load the inputs with the time base stopped, then start it.
    task automatic load_and_run();
        bus.enable = 1'b0;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        bus.enable = 1'b1;
    endtask

    initial begin
        int tbl[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        int prev, hi, e;

        bus.enable = 1'b0; bus.psc = '0; bus.top = '0; bus.center = 1'b0;
        bus.cr1 = '0; bus.cr2 = '0; bus.load = 1'b0;

        #12;
        chk("rst.count", bus.count, 0);
        chk("rst.pwm", bus.pwm, 0);
        chk("rst.ptick", bus.period_tick, 0);
        chk("rst.pend", bus.pending, 0);
        step();
        reset = 1'b1;

        // Edge mode, top=9; ch1 cr1>=cr2 -> 0, ch2 5/5 -> 0, ch3 0/top+1 -> 1.
        bus.psc = 16'd0; bus.top = 16'd9; bus.center = 1'b0;
        set_ch(0, 2, 7); set_ch(1, 0, 0); set_ch(2, 5, 5); set_ch(3, 0, 10);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("edge.pend_stopped", bus.pending, 0);
        chk("edge.count_stopped", bus.count, 0);
        bus.enable = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            bus.load = 1'b0;
            if (j - 1 == 33) begin set_ch(0, 2, 9); bus.load = 1'b1; end
            if (j - 1 == 43) begin set_ch(0, 2, 4); bus.load = 1'b1; end
            if (j - 1 == 49) begin set_ch(0, 2, 6); bus.load = 1'b1; end
            step();
            prev = (j - 1) % 10;
            hi   = (j <= 40) ? 7 : (j <= 50) ? 9 : (j <= 60) ? 4 : 6;
            e    = 8 | (((prev >= 2) && (prev < hi)) ? 1 : 0);
            chk($sformatf("edge.count j=%0d", j), bus.count, j % 10);
            chk($sformatf("edge.ptick j=%0d", j), bus.period_tick, (j % 10 == 0) ? 1 : 0);
            chk($sformatf("edge.pwm j=%0d", j), bus.pwm, e);
            chk($sformatf("edge.pend j=%0d", j), bus.pending,
                (((j >= 34) && (j < 40)) || ((j >= 44) && (j < 60))) ? 1 : 0);
        end
        bus.load = 1'b0;

        bus.enable = 1'b0;
        step();
        chk("dis.count", bus.count, 0);
        chk("dis.pwm", bus.pwm, 0);

        // Center mode, psc=1, top=4.
        bus.psc = 16'd1; bus.top = 16'd4; bus.center = 1'b1;
        set_ch(0, 2, 5); set_ch(1, 0, 3); set_ch(2, 0, 0); set_ch(3, 0, 0);
        load_and_run();
        for (int j = 1; j <= 40; j++) begin
            step();
            prev = tbl[((j - 1) / 2) % 8];
            e    = ((prev < 3) ? 2 : 0) | (((prev >= 2) && (prev < 5)) ? 1 : 0);
            chk($sformatf("ctr.count j=%0d", j), bus.count, tbl[(j / 2) % 8]);
            chk($sformatf("ctr.ptick j=%0d", j), bus.period_tick,
                ((j >= 18) && (j % 16 == 2)) ? 1 : 0);
            chk($sformatf("ctr.pwm j=%0d", j), bus.pwm, e);
        end
        chk("ctr.pend", bus.pending, 0);

        // top=0, psc=2: count pinned at 0, boundary every 3 clocks, ch0 0/1 -> constant 1.
        bus.psc = 16'd2; bus.top = 16'd0; bus.center = 1'b0;
        set_ch(0, 0, 1); set_ch(1, 0, 0);
        load_and_run();
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("top0.count j=%0d", j), bus.count, 0);
            chk($sformatf("top0.ptick j=%0d", j), bus.period_tick, (j % 3 == 0) ? 1 : 0);
            chk($sformatf("top0.pwm j=%0d", j), bus.pwm, 1);
        end
        // Lower psc below the running prescale count: it must wrap, not run on.
        step();
        step();
        bus.psc = 16'd1;
        step();
        chk("pscwrap.a", bus.period_tick, 0);
        step();
        chk("pscwrap.b", bus.period_tick, 0);
        step();
        chk("pscwrap.c", bus.period_tick, 1);

        // Asynchronous reset mid-period with a pending load.
        bus.psc = 16'd0; bus.top = 16'd9; bus.center = 1'b0;
        set_ch(0, 2, 7); set_ch(1, 0, 0); set_ch(2, 0, 0); set_ch(3, 0, 0);
        load_and_run();
        for (int j = 1; j <= 5; j++) step();
        chk("pre.count", bus.count, 5);
        chk("pre.pwm", bus.pwm, 1);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("pre.pend", bus.pending, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.count", bus.count, 0);
        chk("arst.pwm", bus.pwm, 0);
        chk("arst.ptick", bus.period_tick, 0);
        chk("arst.pend", bus.pending, 0);
        step();
        chk("arst.hold", bus.count, 0);
        reset = 1'b1;
        // Settings were cleared: top_a=0, so every clock is a boundary.
        step();
        chk("rel.count", bus.count, 0);
        chk("rel.ptick", bus.period_tick, 1);
        chk("rel.pwm", bus.pwm, 0);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("rel.pend_set", bus.pending, 1);
        chk("rel.count_a", bus.count, 0);
        step();
        chk("rel.pend_clr", bus.pending, 0);
        chk("rel.count_b", bus.count, 0);
        chk("rel.ptick_b", bus.period_tick, 1);
        step();
        chk("rel.count_1", bus.count, 1);
        chk("rel.ptick_1", bus.period_tick, 0);
        step();
        chk("rel.count_2", bus.count, 2);
        chk("rel.pwm_2", bus.pwm, 0);
        step();
        chk("rel.count_3", bus.count, 3);
        chk("rel.pwm_3", bus.pwm, 1);

        bus.enable = 1'b0;
        step();
        chk("end.count", bus.count, 0);
        chk("end.pwm", bus.pwm, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator with a shared prescaler, a programmable period, and per-channel compare windows. All channels share one time base counter. Compare, period and mode settings are double-buffered and take effect only at a period boundary, so changes never produce glitches. It replaces the fixed 200 Hz single-channel PWM for motor/LED/servo outputs driven from the 50 MHz system clock.

## Interface
- `N_CH`, 4: number of PWM channels
- `CNT_W`, 16: time-base counter and compare width
- `PSC_W`, 16: prescaler width
- `clock` in 1: system clock (50 MHz)
- `reset` in 1: reset; one clock, asynchronous, active-low
- `enable` in 1: 1 runs the time base; 0 holds it stopped
- `psc` in PSC_W: prescale value; counter advances once every `psc`+1 clocks
- `top` in CNT_W: period limit (counter maximum)
- `center` in 1: 0 selects edge-aligned mode, 1 selects center-aligned mode
- `cr1` in N_CH*CNT_W: per-channel rise compare; channel i is at bits [i*CNT_W +: CNT_W]
- `cr2` in N_CH*CNT_W: per-channel fall compare; same packing as `cr1`
- `load` in 1: one-clock strobe that captures `top`, `center`, `cr1` and `cr2` into shadow registers
- `pwm` out N_CH: registered channel outputs
- `count` out CNT_W: current time-base value
- `period_tick` out 1: one-clock pulse at each period boundary
- `pending` out 1: shadow values are loaded but not yet applied

## Operation
- **Prescaler:**
  - `psc_cnt` counts 0..`psc` and wraps to 0.
  - `tick`=1 in the cycle where `psc_cnt`==`psc`.
  - With `psc`=0, `tick` is asserted every clock.
  - `psc` is not shadowed; a new value is used immediately.
  - If `psc_cnt` > `psc` after a change, `psc_cnt` wraps to 0 on the next clock.
- **Edge mode:** on each `tick`, `count` goes 0,1,…,top_a, then back to 0. The boundary is the tick where `count`==top_a.
- **Center mode:**
  - On each `tick`, `count` goes 0,1,…,top_a,top_a−1,…,0, then repeats. Each endpoint value is held for exactly one tick.
  - A direction flag (`up`) is internal state.
  - The boundary is the tick where `count`==0 and `up`==0. This is the switch from counting down to counting up.
- **top_a=0:** `count` stays at 0, and every tick is a boundary in both modes.
- **Channel output:** `pwm[i]` is set when (`count` ≥ cr1_a[i]) and (`count` < cr2_a[i]).
  - If cr1_a ≥ cr2_a, the output is constantly 0.
  - If cr2_a > top_a and cr1_a=0, the output is constantly 1.
- **Double-buffering:**
  - `load` copies the inputs into the shadow registers and sets `pending`.
  - At a boundary with `pending`=1, the shadow values are copied into the active registers (_a) and `pending` clears.
  - If `load` and a boundary occur in the same cycle, the boundary copies the previous shadow contents. The new values are captured into the shadow registers and `pending` stays 1.
  - Mode changes at a boundary reset `up` to 1.
- **enable=0:**
  - `psc_cnt`, `count` and `pwm` are forced to 0, and `up` is set to 1.
  - Active registers continuously follow the shadow registers, and `pending` clears.
  - When `enable` rises, counting starts from 0 using the current shadow values.
- **Reset values:** shadow and active registers 0, mode edge, `up`=1, `pending`=0. All outputs 0.
- **Reset mid-period:** all state returns to the reset values immediately (asynchronous). No output glitch is required beyond falling to 0.

## Timing
- `count` changes on the clock edge ending a `tick` cycle.
- `pwm` is registered from the new `count`, so it lags `count` by exactly 1 clock.
- `period_tick` is high in the clock cycle after the boundary edge, coinciding with the first `count` value of the new period. It stays high for 1 clock.
- Active register updates take effect on the same edge as the boundary `count` transition. The first period after an update is compared against the new values.
- Edge-mode period = (`psc`+1)·(top_a+1) clocks. Center-mode period = (`psc`+1)·2·top_a clocks (top_a > 0).
- Width rule: compares are unsigned CNT_W-bit. No arithmetic overflow is possible, because `count` never exceeds top_a.

## Structure
- Package `pwm_pkg`:
  - Mode constants `PWM_EDGE`=0 and `PWM_CENTER`=1.
  - Default widths for `CNT_W` and `PSC_W`.
- Sub-module `pwm_prescaler`:
  - Parameter PSC_W; ports `clock`, `reset`, `enable`, `psc`, `tick`.
  - It owns `psc_cnt` and its wrap handling.
- The top module holds the time base, shadow and active registers, and a generate loop of N_CH comparator/output flops.

## Test plan
- **Edge mode:** `psc`=0, `top`=9, ch0 cr1=2/cr2=7, `load`, `enable`=1 → `count` cycles 0..9, `pwm[0]` high 5 of every 10 clocks, delayed 1 clock from `count`, `period_tick` every 10 clocks.
- **Center mode:** `psc`=1, `top`=4, ch1 cr1=0/cr2=3 → `count` sequence 0,1,2,3,4,3,2,1 (each held 2 clocks), period 16 clocks, `pwm[1]` high while `count`<3.
- **Shadowing:** mid-period `load` with cr2=9 (was 7) → waveform unchanged until the next `period_tick`, then high 7 clocks. `pending` is 1 in between.
- **Load at boundary:** `load` coinciding with the boundary → old shadow applied, new values applied one period later, `pending` stays 1 across the boundary.
- **Degenerate settings:** cr1=5/cr2=5 → constant 0. cr1=0/cr2=`top`+1 → constant 1. `top`=0 → `count` stays 0, `period_tick` every (`psc`+1) clocks.
- **Reset and enable:** `reset` low mid-period → all outputs 0 asynchronously, restart from `count`=0 after release. `enable`=0 → `pwm`=0 and `count`=0.
